// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths: FSM state
// encoding, parity-type and line-level constants, and the default payload
// width.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // PAR_TYP encodings
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Serial line levels for the framing bits
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_tx_bit_timer
// Counts CLK cycles within one serial bit. The counter runs 0..P-1 while the
// transmitter is active and flags the last cycle of each bit.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high reset
//   clear_i     restart the count at 0 (driven when a request is accepted)
//   active_i    a frame is in progress; the counter only runs when high
//   presc_i     cycles per bit, must be >= 1
//   bit_done_o  high in the last cycle of the current bit
// -----------------------------------------------------------------------------
module uart_tx_bit_timer #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      active_i,
    input  logic [PRESCALE_WIDTH-1:0] presc_i,
    output logic                      bit_done_o
);

    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] cnt_q;
    logic [PRESCALE_WIDTH-1:0] cnt_d;
    logic                      last_cycle;

    assign last_cycle = (cnt_q == (presc_i - ONE));
    assign bit_done_o = active_i && last_cycle;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (active_i) begin
            cnt_d = last_cycle ? '0 : (cnt_q + ONE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit engine. Accepts a parallel word via Data_Valid/DV_ACK and sends
// it LSB-first as: start bit, DATA_WIDTH data bits, optional parity, one stop
// bit. Each bit lasts P = max(Prescale, 1) cycles of CLK.
//
// Handshake: Data_Valid is a level request and DV_ACK is the accept strobe.
// A request is taken in any cycle where Data_Valid=1 and the engine is either
// IDLE or in the final cycle of a stop bit; DV_ACK is high in exactly that
// cycle and the word, parity settings and prescale are captured on that edge.
// Data_Valid in any other cycle is ignored; the requester must hold it until
// DV_ACK if it wants the word sent.
//
// Ports:
//   CLK          rising-edge clock
//   RST          synchronous active-high reset
//   P_DATA       word to send
//   Data_Valid   send request
//   PAR_EN       1 = insert a parity bit
//   PAR_TYP      0 = even, 1 = odd parity
//   Prescale     CLK cycles per bit (0 and 1 both mean 1)
//   DV_ACK       accept strobe
//   TX_OUT       registered serial line, idles high
//   Busy         frame in progress
//   dbg_state_o  current FSM state
// -----------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      DV_ACK,
    output logic                      TX_OUT,
    output logic                      Busy,
    output logic [2:0]                dbg_state_o
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0]      LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0]      BIT_ONE  = BIT_CNT_W'(1);
    localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = PRESCALE_WIDTH'(1);

    uart_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                      parity_q, parity_d;
    logic                      par_en_q, par_en_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      tx_q, tx_d;

    logic bit_done;
    logic accept;
    logic active;

    assign active = (state_q != ST_IDLE);

    // Back-to-back acceptance happens in the last stop cycle so the next start
    // bit follows with no idle gap.
    assign accept = Data_Valid && !RST &&
                    ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done));

    uart_tx_bit_timer #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_bit_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .clear_i    (accept),
        .active_i   (active),
        .presc_i    (presc_q),
        .bit_done_o (bit_done)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_START;
            end
            ST_START: begin
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done && (bit_cnt_q == LAST_BIT)) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_done) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_done) state_d = accept ? ST_START : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- Datapath next values ----------------
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        par_en_d  = par_en_q;
        presc_d   = presc_q;
        if (accept) begin
            shift_d   = P_DATA;
            bit_cnt_d = '0;
            parity_d  = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
            par_en_d  = PAR_EN;
            presc_d   = (Prescale <= PRESC_ONE) ? PRESC_ONE : Prescale;
        end else if ((state_q == ST_DATA) && bit_done) begin
            // LSB of shift_q is always the data bit on the line
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
    end

    // ---------------- FSM: outputs ----------------
    // TX_OUT is registered: the line value for the next cycle is chosen from
    // the next state so the output never depends combinationally on inputs.
    always_comb begin
        DV_ACK = accept;
        Busy   = active;
        tx_d   = STOP_BIT;
        unique case (state_d)
            ST_IDLE:   tx_d = STOP_BIT;
            ST_START:  tx_d = START_BIT;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_q;
            ST_STOP:   tx_d = STOP_BIT;
            default:   tx_d = STOP_BIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            par_en_q  <= 1'b0;
            presc_q   <= PRESC_ONE;
            tx_q      <= STOP_BIT;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            par_en_q  <= par_en_d;
            presc_q   <= presc_d;
            tx_q      <= tx_d;
        end
    end

    assign TX_OUT      = tx_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Directed and randomized frames for uart_tx_ctrl. Expected line bits come from
// a frame model (start, data LSB-first, parity from a ones count, stop) pushed
// into exp_q; each bit is expected to hold for max(Prescale,1) cycles.
// Inputs are driven and outputs sampled around the falling edge of CLK.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int DW = 8;
  localparam int PW = 6;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [PW-1:0] Prescale;
  logic          DV_ACK;
  logic          TX_OUT;
  logic          Busy;
  logic [2:0]    dbg_state;

  uart_tx_ctrl #(
    .DATA_WIDTH     (DW),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .P_DATA      (P_DATA),
    .Data_Valid  (Data_Valid),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .Prescale    (Prescale),
    .DV_ACK      (DV_ACK),
    .TX_OUT      (TX_OUT),
    .Busy        (Busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int eff_p(input int p);
    return (p < 2) ? 1 : p;
  endfunction

  // Reference frame: start, data LSB-first, optional parity, stop.
  task automatic push_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp);
    logic par;
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
    if (pen) begin
      par = ptyp ^ (($countones(d) % 2) == 1);
      exp_q.push_back(par);
    end
    exp_q.push_back(1'b1);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge in an idle cycle; leaves at the falling edge of
  // the first frame cycle with the config inputs scrambled.
  task automatic request(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                         input logic [PW-1:0] p, input string tag);
    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Prescale = p; Data_Valid = 1'b1;
    #1 chk({tag, "_ack"}, DV_ACK, 1);
    push_frame(d, pen, ptyp);
    @(negedge CLK);
    Data_Valid = 1'b0;
    P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    Prescale = PW'($urandom);
  endtask

  // Checks the queued frame cycle by cycle. limit>=0 stops early; hold means
  // Data_Valid stays high (ack expected only in the last stop cycle); poke
  // raises Data_Valid with 0xFF for one cycle at that frame cycle.
  task automatic check_frame(input int p, input int limit, input bit hold,
                             input int poke, input string tag);
    logic [0:0] bits[$];
    int full;
    int n;
    bits = exp_q;
    exp_q.delete();
    full = bits.size() * p;
    n = (limit >= 0) ? limit : full;
    for (int k = 0; k < n; k++) begin
      if (poke == k) begin
        Data_Valid = 1'b1;
        P_DATA = 8'hFF;
      end
      #1;
      chk($sformatf("%s_tx%0d", tag, k), TX_OUT, bits[k / p]);
      chk($sformatf("%s_busy%0d", tag, k), Busy, 1);
      chk($sformatf("%s_ack%0d", tag, k), DV_ACK, (hold && k == full - 1) ? 1 : 0);
      @(negedge CLK);
      if (poke == k) Data_Valid = 1'b0;
    end
    if (!hold && limit < 0) begin
      #1;
      chk({tag, "_idle_tx"}, TX_OUT, 1);
      chk({tag, "_idle_busy"}, Busy, 0);
      chk({tag, "_idle_state"}, dbg_state, 0);
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      #1;
      chk($sformatf("%s_tx%0d", tag, k), TX_OUT, 1);
      chk($sformatf("%s_busy%0d", tag, k), Busy, 0);
    end
    @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] rd;
    logic          rpen, rtyp;
    logic [PW-1:0] rp;

    RST = 1'b1; Data_Valid = 1'b1; P_DATA = 8'h5A; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    Prescale = 6'd8;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_ack", DV_ACK, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge CLK);
    RST = 1'b0; Data_Valid = 1'b0;
    @(negedge CLK);

    // 0xA5, no parity, P=8
    request(8'hA5, 1'b0, 1'b0, 6'd8, "a5p8");
    check_frame(8, -1, 0, -1, "a5p8");

    // 0xA5 with even then odd parity, P=4
    request(8'hA5, 1'b1, 1'b0, 6'd4, "even");
    check_frame(4, -1, 0, -1, "even");
    request(8'hA5, 1'b1, 1'b1, 6'd4, "odd");
    check_frame(4, -1, 0, -1, "odd");

    // back-to-back 0x3C then 0xC3, P=2, Data_Valid held
    request(8'h3C, 1'b0, 1'b0, 6'd2, "b2b");
    Data_Valid = 1'b1; P_DATA = 8'hC3; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd2;
    check_frame(2, -1, 1, -1, "b2b1");
    Data_Valid = 1'b0;
    push_frame(8'hC3, 1'b0, 1'b0);
    check_frame(2, -1, 0, -1, "b2b2");

    // request while busy is ignored
    request(8'h00, 1'b0, 1'b0, 6'd4, "ign");
    check_frame(4, -1, 0, 12, "ign");
    idle_cycles(6, "ign_after");

    // reset in cycle 25 of a P=8 frame, then a clean 0x55
    request(8'hE7, 1'b1, 1'b0, 6'd8, "mid");
    check_frame(8, 24, 0, -1, "mid");
    RST = 1'b1;
    @(negedge CLK);
    #1;
    chk("midrst_tx", TX_OUT, 1);
    chk("midrst_busy", Busy, 0);
    chk("midrst_state", dbg_state, 0);
    RST = 1'b0;
    @(negedge CLK);
    request(8'h55, 1'b0, 1'b0, 6'd8, "post");
    check_frame(8, -1, 0, -1, "post");

    // Prescale 0 and 1 both give 1 cycle per bit
    request(8'h81, 1'b0, 1'b0, 6'd0, "p0");
    check_frame(1, -1, 0, -1, "p0");
    request(8'h81, 1'b0, 1'b0, 6'd1, "p1");
    check_frame(1, -1, 0, -1, "p1");

    // randomized frames
    for (int i = 0; i < 12; i++) begin
      rd   = DW'($urandom);
      rpen = 1'($urandom);
      rtyp = 1'($urandom);
      rp   = PW'($urandom_range(0, 6));
      request(rd, rpen, rtyp, rp, $sformatf("rnd%0d", i));
      check_frame(eff_p(int'(rp)), -1, 0, -1, $sformatf("rnd%0d", i));
      idle_cycles($urandom_range(0, 3), $sformatf("rnd%0d_gap", i));
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
